// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents: FSM state encoding, column drive rotation, 16-entry key map and
// small row-decode helpers used by the scanner datapath.

package keypad_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } kp_state_t;

    // Rows are active-low and pulled up, so an idle sample reads all ones.
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Column drive is active-low one-hot. Entry c drives column c low;
    // rotation walks c = 0,1,2,3,0 ...
    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0][3:0] COL_DRIVE = {
        4'b0111,    // column 3
        4'b1011,    // column 2
        4'b1101,    // column 1
        4'b1110     // column 0
    };

    // Key map indexed by {row[1:0], col[1:0]}.
    //   r0 = 1 2 3 A   r1 = 4 5 6 B   r2 = 7 8 9 C   r3 = 0 F E D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,     // row 3, cols 3..0
        4'hC, 4'h9, 4'h8, 4'h7,     // row 2, cols 3..0
        4'hB, 4'h6, 4'h5, 4'h4,     // row 1, cols 3..0
        4'hA, 4'h3, 4'h2, 4'h1      // row 0, cols 3..0
    };

    // True when exactly one row line is pulled low. Two or more low rows
    // in the same column slot is a chord or a ghost and is not a key.
    function automatic logic single_low(input logic [3:0] rows);
        logic hit;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Index of the low row. Only meaningful when single_low() is true.
    function automatic logic [1:0] low_row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, loads RESET_VAL into both stages
//   d      - asynchronous input bus (each bit synchronized independently)
//   q      - synchronized output bus

module sync2 #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce; emits one strobe per accepted key.
// Latency: DEBOUNCE scan ticks + 1 clk from first qualifying tick to KEY_VALID.
// Backpressure: none; KEY_VALID is a one-cycle strobe, consumer must take it.
//
// Ports:
//   clk        - system clock, all state on rising edge
//   RESET_N    - asynchronous active-low reset
//   ROW[3:0]   - row sense lines, active-low, asynchronous to clk
//   COL[3:0]   - column drive, active-low one-hot
//   KEY_CODE   - hex value of the last accepted key, held until the next one
//   KEY_VALID  - single-cycle strobe, KEY_CODE valid in the same cycle
//   KEY_HELD   - high from acceptance until the release has been debounced
//
// KEY_VALID/KEY_CODE are shaped to drop straight into a nibble shift-register
// display path as its enable and data nibble.

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,     // clk cycles per column slot, >= 2
    parameter int DEBOUNCE = 4          // matching ticks to accept, 1..15
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam int                 DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [3:0]         DB_TARGET = 4'(DEBOUNCE);

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [3:0] row_s;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (ROWS_IDLE)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (RESET_N),
        .d     (ROW),
        .q     (row_s)
    );

    // ------------------------------------------------------------------
    // Scan tick divider: counts 0..SCAN_DIV-1, tick on the last count.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    kp_state_t  state_q;
    kp_state_t  state_d;

    logic [1:0] col_idx;        // column currently driven
    logic [1:0] col_nxt;
    logic [3:0] key_rows;       // row pattern that started the debounce
    logic [3:0] key_idx;        // {row, col} of the candidate key
    logic [3:0] db_cnt;         // press-match count, then release count
    logic [3:0] db_cnt_inc;

    // Per-tick decisions on the synchronized row sample.
    logic row_single;
    logic row_match;
    logic rows_idle;
    logic cnt_hit;

    assign col_nxt    = col_idx + 2'd1;
    assign db_cnt_inc = db_cnt + 4'd1;
    assign row_single = single_low(row_s);
    // The same single row must stay low; a second row joining in breaks it.
    assign row_match  = (row_s == key_rows);
    assign rows_idle  = (row_s == ROWS_IDLE);
    // The count that this tick would complete reaches the debounce target.
    assign cnt_hit    = (db_cnt_inc == DB_TARGET);

    // Control strobes from the output process.
    logic ld_key;
    logic adv_col;
    logic accept;
    logic release_done;
    logic cnt_clr;
    logic cnt_inc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Everything advances only on a scan tick.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (row_single) begin
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_match) begin
                        state_d = ST_SCAN;
                    end else if (cnt_hit) begin
                        state_d = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (rows_idle && cnt_hit) begin
                        state_d = ST_SCAN;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output/control logic
    // ------------------------------------------------------------------
    always_comb begin
        ld_key       = 1'b0;
        adv_col      = 1'b0;
        accept       = 1'b0;
        release_done = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (row_single) begin
                        ld_key  = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        adv_col = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_match) begin
                        // Bounce or a chord: drop the candidate silently.
                        adv_col = 1'b1;
                        cnt_clr = 1'b1;
                    end else if (cnt_hit) begin
                        accept  = 1'b1;
                        cnt_clr = 1'b1;     // counter is reused for release
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_HELD: begin
                    // Column stays frozen, so only keys sharing this column
                    // can be seen; any low row restarts the release count.
                    if (!rows_idle) begin
                        cnt_clr = 1'b1;
                    end else if (cnt_hit) begin
                        release_done = 1'b1;
                        adv_col      = 1'b1;
                        cnt_clr      = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: begin
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers. All outputs come straight from these flops.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            col_idx   <= 2'd0;
            COL       <= COL_RESET;
            key_rows  <= ROWS_IDLE;
            key_idx   <= 4'd0;
            db_cnt    <= 4'd0;
            KEY_CODE  <= 4'h0;
            KEY_VALID <= 1'b0;
            KEY_HELD  <= 1'b0;
        end else begin
            KEY_VALID <= accept;

            if (adv_col) begin
                col_idx <= col_nxt;
                COL     <= COL_DRIVE[col_nxt];
            end

            if (ld_key) begin
                key_rows <= row_s;
                key_idx  <= {low_row_index(row_s), col_idx};
            end

            if (cnt_clr) begin
                db_cnt <= 4'd0;
            end else if (cnt_inc) begin
                db_cnt <= db_cnt_inc;
            end

            if (accept) begin
                KEY_CODE <= KEY_MAP[key_idx];
                KEY_HELD <= 1'b1;
            end else if (release_done) begin
                KEY_HELD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
// A physical keypad is emulated from key_down[] and the DUT's column drive;
// a cycle model and literal checks judge the outputs.

module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;

    logic        clk     = 1'b0;
    logic        RESET_N = 1'b0;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [3:0]  KEY_CODE;
    logic        KEY_VALID;
    logic        KEY_HELD;
    logic [15:0] key_down = '0;     // bit r*4+c = key at row r, column c

    int tests     = 0;
    int fails     = 0;
    int edge_cnt  = 0;              // rising edges since reset release
    int pulse_cnt = 0;              // KEY_VALID strobes seen

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DB)
    ) dut (
        .clk       (clk),
        .RESET_N   (RESET_N),
        .ROW       (ROW),
        .COL       (COL),
        .KEY_CODE  (KEY_CODE),
        .KEY_VALID (KEY_VALID),
        .KEY_HELD  (KEY_HELD)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key sits in a driven column.
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!COL[c] && key_down[r*4+c]) begin
                    ROW[r] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model, evaluated once per clock edge at the negedge.
    // ------------------------------------------------------------------
    logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'h0, 4'hF, 4'hE, 4'hD};

    int         m_edges = 0;
    logic [3:0] m_last  = 4'hF;     // ROW just before the coming edge
    logic [3:0] m_ff1   = 4'hF;
    logic [3:0] m_ff2   = 4'hF;
    int         m_mode  = 0;        // 0 scanning, 1 confirming, 2 holding
    int         m_pos   = 0;
    int         m_r     = 0;
    int         m_c     = 0;
    int         m_hits  = 0;
    int         m_quiet = 0;
    logic [3:0] m_code  = 4'h0;
    logic       m_valid = 1'b0;
    logic       m_held  = 1'b0;

    always @(negedge clk) begin
        logic [3:0] v;
        logic [3:0] ecol;
        int zeros;
        int zr;
        if (!RESET_N) begin
            m_edges = 0; m_ff1 = 4'hF; m_ff2 = 4'hF;
            m_mode = 0; m_pos = 0; m_hits = 0; m_quiet = 0;
            m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
        end else if (edge_cnt != m_edges) begin
            m_edges = edge_cnt;
            v = m_ff2;
            m_ff2 = m_ff1;
            m_ff1 = m_last;
            m_valid = 1'b0;
            if (m_edges % SCAN_DIV == 0) begin
                zeros = 0;
                zr = 0;
                for (int i = 0; i < 4; i++) begin
                    if (!v[i]) begin
                        zeros++;
                        zr = i;
                    end
                end
                case (m_mode)
                    0: begin
                        if (zeros == 1) begin
                            m_r = zr; m_c = m_pos; m_hits = 0; m_mode = 1;
                        end else begin
                            m_pos = (m_pos + 1) % 4;
                        end
                    end
                    1: begin
                        if (zeros == 1 && zr == m_r) begin
                            m_hits++;
                            if (m_hits == DB) begin
                                m_code = km[m_r*4 + m_c];
                                m_valid = 1'b1; m_held = 1'b1;
                                m_quiet = 0; m_mode = 2;
                            end
                        end else begin
                            m_mode = 0;
                            m_pos = (m_pos + 1) % 4;
                        end
                    end
                    default: begin
                        if (zeros == 0) begin
                            m_quiet++;
                            if (m_quiet == DB) begin
                                m_held = 1'b0; m_mode = 0;
                                m_pos = (m_pos + 1) % 4;
                            end
                        end else begin
                            m_quiet = 0;
                        end
                    end
                endcase
            end
        end
        if (KEY_VALID === 1'b1) pulse_cnt++;
        ecol = ~(4'b0001 << m_pos);
        check("cycle_outputs", 32'({COL, KEY_CODE, KEY_VALID, KEY_HELD}),
              32'({ecol, m_code, m_valid, m_held}));
        m_last = ROW;
    end

    task automatic goto_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #30000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations.
    // Inputs change 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_col",   32'(COL),       32'h0000_000E);
        check("rst_code",  32'(KEY_CODE),  32'h0);
        check("rst_valid", 32'(KEY_VALID), 32'h0);
        check("rst_held",  32'(KEY_HELD),  32'h0);
        RESET_N = 1'b1;

        // Idle scan: first tick at edge 4, then every 4 edges.
        goto_edge(3);  check("idle_col_e3",  32'(COL), 32'hE);
        goto_edge(4);  check("idle_col_e4",  32'(COL), 32'hD);
        goto_edge(8);  check("idle_col_e8",  32'(COL), 32'hB);
        goto_edge(12); check("idle_col_e12", 32'(COL), 32'h7);
        goto_edge(15); check("idle_col_e15", 32'(COL), 32'h7);
        goto_edge(16); check("idle_col_e16", 32'(COL), 32'hE);

        // Key 5 (r1,c1): seen at tick 24, accepted at tick 36.
        goto_edge(20);
        check("k5_col_before", 32'(COL), 32'hD);
        check("idle_no_pulse", 32'(pulse_cnt), 32'd0);
        key_down[1*4+1] = 1'b1;
        goto_edge(35); check("k5_valid_e35", 32'(KEY_VALID), 32'h0);
        goto_edge(36);
        check("k5_valid_e36", 32'(KEY_VALID), 32'h1);
        check("k5_code",      32'(KEY_CODE),  32'h5);
        check("k5_held_e36",  32'(KEY_HELD),  32'h1);
        goto_edge(37);
        check("k5_valid_e37", 32'(KEY_VALID), 32'h0);
        check("k5_held_e37",  32'(KEY_HELD),  32'h1);
        goto_edge(40);
        key_down[1*4+1] = 1'b0;
        goto_edge(51); check("k5_held_e51", 32'(KEY_HELD), 32'h1);
        goto_edge(52);
        check("k5_held_e52", 32'(KEY_HELD), 32'h0);
        check("k5_col_e52",  32'(COL),      32'hB);
        check("k5_one_pulse", 32'(pulse_cnt), 32'd1);

        // Key E (r3,c2) held for 2 ticks only: bounce, no strobe.
        key_down[3*4+2] = 1'b1;
        goto_edge(60);
        key_down[3*4+2] = 1'b0;
        goto_edge(63); check("bounce_col_e63", 32'(COL), 32'hB);
        goto_edge(64);
        check("bounce_col_e64", 32'(COL),      32'h7);
        check("bounce_valid",   32'(KEY_VALID), 32'h0);

        // Keys 3 and C together in column 3: ghost, scanning continues.
        key_down[0*4+3] = 1'b1;
        key_down[2*4+3] = 1'b1;
        goto_edge(68); check("ghost_col_e68", 32'(COL), 32'hE);
        goto_edge(72); check("ghost_col_e72", 32'(COL), 32'hD);
        goto_edge(85); check("ghost_col_e85", 32'(COL), 32'hE);
        key_down[0*4+3] = 1'b0;
        key_down[2*4+3] = 1'b0;
        goto_edge(88); check("ghost_no_pulse", 32'(pulse_cnt), 32'd1);

        // Key 9 (r2,c2): reset in the middle of debouncing.
        goto_edge(92);
        key_down[2*4+2] = 1'b1;
        goto_edge(101);
        check("k9_col_frozen", 32'(COL),      32'hB);
        check("k9_held_pre",   32'(KEY_HELD), 32'h0);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_col",   32'(COL),       32'hE);
        check("mid_rst_code",  32'(KEY_CODE),  32'h0);
        check("mid_rst_valid", 32'(KEY_VALID), 32'h0);
        check("mid_rst_held",  32'(KEY_HELD),  32'h0);
        key_down[2*4+2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        RESET_N = 1'b1;

        // Fresh press of key 9 after reset: seen at tick 12, accepted at 24.
        goto_edge(8);
        check("post_rst_no_pulse", 32'(pulse_cnt), 32'd1);
        key_down[2*4+2] = 1'b1;
        goto_edge(24);
        check("k9_valid", 32'(KEY_VALID), 32'h1);
        check("k9_code",  32'(KEY_CODE),  32'h9);
        goto_edge(28);
        key_down[2*4+2] = 1'b0;
        goto_edge(40);
        check("k9_held_e40", 32'(KEY_HELD), 32'h0);
        check("k9_col_e40",  32'(COL),      32'h7);

        // Key A (r0,c3), then key 7 (r2,c0) pressed while A is held.
        key_down[0*4+3] = 1'b1;
        goto_edge(56);
        check("kA_valid", 32'(KEY_VALID), 32'h1);
        check("kA_code",  32'(KEY_CODE),  32'hA);
        goto_edge(60);
        key_down[2*4+0] = 1'b1;
        goto_edge(64);
        key_down[0*4+3] = 1'b0;
        goto_edge(75);
        check("kA_held_e75",  32'(KEY_HELD),  32'h1);
        check("kA_code_hold", 32'(KEY_CODE),  32'hA);
        goto_edge(76);
        check("kA_held_e76", 32'(KEY_HELD), 32'h0);
        check("kA_col_e76",  32'(COL),      32'hE);
        goto_edge(91); check("k7_valid_e91", 32'(KEY_VALID), 32'h0);
        goto_edge(92);
        check("k7_valid", 32'(KEY_VALID), 32'h1);
        check("k7_code",  32'(KEY_CODE),  32'h7);
        goto_edge(96);
        key_down[2*4+0] = 1'b0;
        check("total_pulses", 32'(pulse_cnt), 32'd4);
        goto_edge(110);
        check("k7_released", 32'(KEY_HELD), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, gives the clk cycles per scan tick (column slot); legal values are 2 and above.
REQ-002 Parameter DEBOUNCE, default 4, gives the number of consecutive matching ticks needed to accept a press or a release; legal values are 1 to 15.
REQ-003 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 Port ROW  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 Port COL  output  4  keypad column drive, active-low, one-hot-low.
REQ-007 Port KEY_CODE  output  4  hex value of the last accepted key.
REQ-008 Port KEY_VALID  output  1  single-cycle strobe marking a newly accepted key; KEY_CODE is valid in that cycle.
REQ-009 Port KEY_HELD  output  1  high from acceptance until the release is accepted.

Function
REQ-010 ROW shall pass through a two-flop synchronizer; all logic uses only the synchronized value.
REQ-011 The divider shall count 0 to SCAN_DIV-1 and raise a one-cycle tick when it reaches SCAN_DIV-1, then wrap to 0.
REQ-012 The FSM states shall be SCAN, DEBOUNCE and HELD.
REQ-013 In SCAN, on each tick:
- sample the synchronized rows for the current column;
- exactly one row low: latch the row/column pair, clear the match counter, go to DEBOUNCE with the column frozen;
- otherwise: rotate COL 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-014 Two or more rows low in one sample is a ghost/chord; it shall be ignored and scanning continues.
REQ-015 In DEBOUNCE, on each tick:
- same single row still low: increment the match counter;
- on reaching DEBOUNCE: update KEY_CODE, pulse KEY_VALID in the next cycle, set KEY_HELD, go to HELD;
- any other pattern: return to SCAN and advance the column, with no strobe.
REQ-016 In HELD, the column stays frozen. Each tick with all rows high increments the release counter; any low row clears it. When the counter reaches DEBOUNCE, clear KEY_HELD and go to SCAN, advancing the column.
REQ-017 Key map, by row r and column c: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-018 KEY_VALID shall pulse exactly once per accepted press and never while KEY_HELD is already high.
REQ-019 KEY_CODE shall hold its value until the next accepted key.
REQ-020 Latency from the first qualifying tick to the KEY_VALID pulse shall be DEBOUNCE ticks plus one clk cycle.
REQ-021 A second key pressed while in HELD shall be ignored until the release is accepted.

Reset
REQ-022 While RESET_N is low, all state shall clear asynchronously:
- divider = 0, counters = 0, state = SCAN;
- COL = 4'b1110, KEY_CODE = 4'h0, KEY_VALID = 0, KEY_HELD = 0;
- synchronizer flops = 4'b1111.
REQ-023 Reset asserted mid-DEBOUNCE or mid-HELD shall abort the operation without any KEY_VALID pulse.
REQ-024 After RESET_N rises, operation shall resume with the first tick SCAN_DIV cycles later.

Structure
REQ-025 A shared package keypad_pkg shall hold the FSM state encoding, the 16-entry key map and the column rotation constants.
REQ-026 The synchronizer shall be a separate sub-module, sync2, instantiated four bits wide.
REQ-027 Outputs KEY_VALID, KEY_CODE, KEY_HELD and COL shall be driven directly from flops.
REQ-028 KEY_VALID and KEY_CODE shall be able to feed the existing nibble shift-register display path directly, in place of the filtered button enable and switch nibble.

Verification (bench parameters SCAN_DIV=4, DEBOUNCE=3)
REQ-029 Idle, no key pressed -> COL cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; KEY_VALID stays 0.
REQ-030 Hold the r1/c1 key through acceptance, then release -> one KEY_VALID with KEY_CODE=4'h5; KEY_HELD falls 3 ticks after release.
REQ-031 Hold the r3/c2 key for only 2 ticks (bounce) -> no KEY_VALID; scanning resumes at the next column.
REQ-032 Press r0 and r2 together in c3 -> no KEY_VALID; COL keeps rotating.
REQ-033 Drop RESET_N during DEBOUNCE for key 9 -> outputs return to reset values immediately; no KEY_VALID until a fresh press is accepted after reset.
REQ-034 Press key A, then press key 7 while A is still held -> one pulse with code 4'hA; after A's release is accepted, one pulse with code 4'h7.
